// File: rtl/mnist_stream_pkg.sv
// Shared constants, state encoding and sizing helper for the MNIST image streamer.
package mnist_stream_pkg;

    localparam int unsigned IMG_W = 28;
    localparam int unsigned IMG_H = 28;
    localparam int unsigned NPIX  = IMG_W * IMG_H;

    // Whole images that fit in a 2^aw-word ROM.
    function automatic int unsigned num_img(input int unsigned aw, input int unsigned npix);
        longint unsigned span;
        span = 64'd1 << aw;
        return int'(span / 64'(npix));
    endfunction

    localparam int unsigned NUM_IMG = num_img(16, NPIX);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO with a registered head word; absorbs ROM latency under backpressure.
module pix_skid_fifo #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop_ok, push_ok;

    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) head_d = din;
                else                 tail_d = din;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop keeps occupancy; shift tail forward when full.
                if (count_q == 2'd1) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = head_q;
    assign valid = (count_q != 2'd0);
    assign count = count_q;

endmodule

// File: rtl/mnist_image_streamer.sv
// Streams one 28x28 image from a 1-cycle-latency ROM as a valid/ready pixel stream
// with sof/eol/eof framing flags.
module mnist_image_streamer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned IMG_W      = mnist_stream_pkg::IMG_W,
    parameter int unsigned IMG_H      = mnist_stream_pkg::IMG_H,
    parameter int unsigned IDX_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IDX_WIDTH-1:0]  img_idx,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  pix_eof,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    import mnist_stream_pkg::*;

    localparam int unsigned PIX_PER_IMG = IMG_W * IMG_H;
    localparam int unsigned IMG_LIMIT   = num_img(ADDR_WIDTH, PIX_PER_IMG);
    localparam int unsigned CW          = $clog2(IMG_W);
    localparam int unsigned RW          = $clog2(IMG_H);
    localparam int unsigned IW          = $clog2(PIX_PER_IMG + 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IW-1:0]         issued_q, issued_d;
    logic                  rd_pend_q;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [1:0]  fifo_count;
    logic        pop, issue, credit_ok, idx_ok, last_col, last_row;
    logic [2:0]  occ;
    logic [31:0] base_full;

    assign pop      = pix_valid && pix_ready;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));
    assign idx_ok   = (32'(img_idx) < IMG_LIMIT);
    assign base_full = 32'(img_idx) * PIX_PER_IMG;

    // Words buffered plus in flight, net of this cycle's pop, must stay within 2.
    assign occ       = 3'(fifo_count) + 3'(rd_pend_q);
    assign credit_ok = (occ < (3'd2 + 3'(pop)));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        row_d    = row_q;
        col_d    = col_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        issue    = 1'b0;

        if (pop) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (idx_ok) begin
                        addr_d   = base_full[ADDR_WIDTH-1:0];
                        issued_d = '0;
                        row_d    = '0;
                        col_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + IW'(1);
                    if (issued_q == IW'(PIX_PER_IMG - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The eof beat is the last word, so its handshake implies an empty pipeline.
                if (pop && pix_eof) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            issued_q  <= '0;
            rd_pend_q <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            issued_q  <= issued_d;
            rd_pend_q <= issue;
            row_q     <= row_d;
            col_q     <= col_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    pix_skid_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pend_q),
        .din   (rom_q),
        .pop   (pop),
        .dout  (pix_data),
        .valid (pix_valid),
        .count (fifo_count)
    );

    assign rom_addr = addr_q;
    assign pix_sof  = pix_valid && (row_q == '0) && (col_q == '0);
    assign pix_eol  = pix_valid && last_col;
    assign pix_eof  = pix_valid && last_row && last_col;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mnist_image_streamer.sv
// Bench for mnist_image_streamer: ROM model, per-cycle stream scoreboard, directed scenarios.
module tb_mnist_image_streamer;

    localparam int NPIX    = 784;
    localparam int NUM_IMG = 83;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  img_idx = '0;
    logic [15:0] rom_addr;
    logic [15:0] rom_q = '0;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_sof, pix_eol, pix_eof, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    int c0       = 0;

    // Model state
    bit          m_busy = 0, m_done = 0, m_err = 0;
    int          m_base = 0, m_beat = 0, m_fv_cyc = 0;
    bit          m_fv_seen = 0;
    logic [15:0] m_first_data = '0, m_last_data = '0;
    bit          prev_stall = 0;
    logic [15:0] prev_data = '0;

    mnist_image_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .img_idx   (img_idx),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .pix_eof   (pix_eof),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        return a * 16'd7 + 16'd3;
    endfunction

    always @(posedge clk) rom_q <= rom_fn(rom_addr);

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       pix_ready = 1'($urandom_range(0, 1));
            2:       pix_ready = 1'b0;
            default: pix_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare this cycle, then advance the model with what the next edge samples.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs",
                {rom_addr, pix_data != 16'd0, pix_valid, pix_sof, pix_eol, pix_eof, busy, done, err},
                32'd0);
            m_busy = 0; m_done = 0; m_err = 0; m_beat = 0; prev_stall = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("valid_allowed", pix_valid && !m_busy, 0);
            if (pix_valid && m_busy) begin
                chk("beat", {pix_data, pix_sof, pix_eol, pix_eof},
                    {rom_fn(16'(m_base + m_beat)), m_beat == 0, (m_beat % 28) == 27,
                     m_beat == NPIX - 1});
                if (!m_fv_seen) begin
                    m_fv_seen = 1; m_fv_cyc = cyc; m_first_data = pix_data;
                end
            end
            if (prev_stall) chk("stall_hold", {pix_valid, pix_data}, {1'b1, prev_data});
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;

            m_done = 0;
            m_err  = 0;
            if (start && !m_busy) begin
                if (int'(img_idx) < NUM_IMG) begin
                    m_busy = 1; m_base = int'(img_idx) * NPIX; m_beat = 0; m_fv_seen = 0;
                end else begin
                    m_err = 1;
                end
            end else if (pix_valid && pix_ready && m_busy) begin
                if (m_beat == NPIX - 1) begin
                    m_done = 1; m_busy = 0; m_last_data = pix_data;
                end
                m_beat++;
            end
        end
    end

    // Call at #1 after an edge; start is sampled on the next edge (E0).
    task automatic do_start(input int idx);
        start = 1'b1;
        img_idx = 7'(idx);
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input int budget, output int at);
        int k = 0;
        at = -1;
        while (k < budget && at < 0) begin
            @(posedge clk);
            #1;
            k++;
            if (done) at = cyc;
        end
        chk("done_within_budget", at >= 0, 1);
    endtask

    task automatic wait_beat(input int n);
        int k = 0;
        while (m_beat < n && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("beat_reached", m_beat >= n, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_valid", pix_valid, 0);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_outputs", {rom_addr, pix_data, pix_valid, busy, done, err}, 0);

        // Image 0, full rate: latency and total duration.
        do_start(0);
        chk("img0_base", rom_addr, 0);
        chk("img0_busy", busy, 1);
        wait_done(2000, at);
        chk("img0_done_latency", at - c0, 786);
        chk("img0_first_valid_latency", m_fv_cyc - c0, 2);
        chk("img0_last_word", m_last_data, 5484);

        // Start in the done cycle is accepted.
        do_start(1);
        chk("img1_base", rom_addr, 784);
        wait_done(2000, at);

        // Image 3 with random backpressure and one long stall.
        rdy_mode = 1;
        do_start(3);
        chk("img3_base", rom_addr, 2352);
        wait_beat(200);
        rdy_mode = 2;
        repeat (12) @(posedge clk);
        #1;
        chk("stall_issue_held", rom_addr, 2352 + 200 + 2);
        rdy_mode = 1;
        wait_done(6000, at);
        chk("img3_first_word", m_first_data, 16467);
        chk("img3_last_word", m_last_data, 21948);
        rdy_mode = 0;

        // Out-of-range index.
        do_start(83);
        chk("img83_err", err, 1);
        chk("img83_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("img83_no_valid", pix_valid, 0);

        // Last image, with a start pulse mid-stream that must be ignored.
        do_start(82);
        chk("img82_base", rom_addr, 64288);
        wait_beat(100);
        start = 1'b1;
        img_idx = 7'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2000, at);
        chk("img82_first_word", m_first_data, 56803);
        chk("img82_last_word", m_last_data, 62284);

        // Asynchronous reset mid-image, then a fresh image.
        do_start(2);
        wait_beat(400);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", {rom_addr, pix_data, pix_valid, busy, done}, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_no_done", done, 0);
        do_start(5);
        chk("img5_base", rom_addr, 3920);
        wait_done(2000, at);
        chk("img5_done_latency", at - c0, 786);
        chk("img5_first_word", m_first_data, 27443);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
